// File: rtl/bsg_mem_nr1w_sync_init.sv
// Synchronous-read register file: rports_p read ports, one bit-masked write port,
// optional write-to-read bypass, and a self-running init sweep after reset.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_mem_nr1w_sync_init
  #(parameter int width_p                  = 8
   ,parameter int els_p                    = 12
   ,parameter int rports_p                 = 2
   ,parameter bit write_bypass_p           = 1'b0
   ,parameter logic [width_p-1:0] init_val_p = '0
   ,localparam int addr_width_lp           = `BSG_SAFE_CLOG2(els_p)
   )
  (input  logic                                clk_i
   ,input  logic                               reset_i
   ,input  logic                               w_v_i
   ,input  logic [addr_width_lp-1:0]           w_addr_i
   ,input  logic [width_p-1:0]                 w_data_i
   ,input  logic [width_p-1:0]                 w_mask_i
   ,input  logic [rports_p-1:0]                r_v_i
   ,input  logic [rports_p*addr_width_lp-1:0]  r_addr_i
   ,output logic [rports_p*width_p-1:0]        r_data_o
   ,output logic                               ready_o
   );

   // state | meaning
   // INIT  | sweeping init_val_p into mem[0..els_p-1], ports ignored
   // READY | normal traffic: one masked write plus rports_p reads per cycle
   typedef enum logic {INIT, READY} state_e;

   localparam logic [addr_width_lp:0]   els_lp  = (addr_width_lp+1)'(els_p);
   localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p-1);

   state_e                                 state_r, state_n;
   logic [addr_width_lp-1:0]               cnt_r, cnt_n;
   logic [width_p-1:0]                     mem_r [els_p];
   logic [rports_p-1:0][width_p-1:0]       r_data_r, r_data_n;
   logic [rports_p-1:0][addr_width_lp-1:0] r_addr;
   logic [rports_p-1:0]                    r_in_range;
   logic                                   w_in_range;
   logic [width_p-1:0]                     w_old, w_merged;

   assign r_addr     = r_addr_i;
   assign r_data_o   = r_data_r;
   assign ready_o    = (state_r == READY);

   assign w_in_range = ({1'b0, w_addr_i} < els_lp);
   assign w_old      = w_in_range ? mem_r[w_addr_i] : '0;
   assign w_merged   = (w_old & ~w_mask_i) | (w_data_i & w_mask_i);

   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      case (state_r)
         INIT: begin
            cnt_n = cnt_r + 1'b1;
            if (cnt_r == last_lp)
               state_n = READY;
         end
         default: ;
      endcase
   end

   // Bypass forwards the merged word so a colliding read never sees stale data.
   always_comb begin
      r_data_n   = r_data_r;
      r_in_range = '0;
      for (int k = 0; k < rports_p; k++) begin
         r_in_range[k] = ({1'b0, r_addr[k]} < els_lp);
         if (state_r == INIT)
            r_data_n[k] = '0;
         else if (r_v_i[k]) begin
            if (!r_in_range[k])
               r_data_n[k] = '0;
            else if (write_bypass_p && w_v_i && w_in_range && (r_addr[k] == w_addr_i))
               r_data_n[k] = w_merged;
            else
               r_data_n[k] = mem_r[r_addr[k]];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r  <= INIT;
         cnt_r    <= '0;
         r_data_r <= '0;
      end
      else begin
         state_r  <= state_n;
         cnt_r    <= cnt_n;
         r_data_r <= r_data_n;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         if (state_r == INIT)
            mem_r[cnt_r] <= init_val_p;
         else if (w_v_i && w_in_range)
            mem_r[w_addr_i] <= w_merged;
      end
   end

`ifndef BSG_HIDE_FROM_SYNTHESIS
   always @(posedge clk_i) begin
      if (!reset_i) begin
         if (state_r == INIT) begin
            assert (!w_v_i && (r_v_i == '0))
               else $error("bsg_mem_nr1w_sync_init: access while initialising");
         end
         else begin
            assert (!w_v_i || w_in_range)
               else $error("bsg_mem_nr1w_sync_init: write address %0d out of range", w_addr_i);
            for (int k = 0; k < rports_p; k++)
               assert (!r_v_i[k] || r_in_range[k])
                  else $error("bsg_mem_nr1w_sync_init: port %0d read address %0d out of range", k, r_addr[k]);
         end
      end
   end
`endif

endmodule

// File: tb/tb_bsg_mem_nr1w_sync_init.sv
// Bench for bsg_mem_nr1w_sync_init: both bypass modes side by side, directed
// scenarios followed by a random soak against an array-based reference model.
module tb_bsg_mem_nr1w_sync_init;

   localparam int W = 8, E = 12, P = 3, AW = 4;
   localparam logic [7:0] IV = 8'hA5;

   logic          clk = 1'b0;
   logic          reset;
   logic          w_v;
   logic [AW-1:0] w_addr;
   logic [W-1:0]  w_data, w_mask;
   logic [P-1:0]  r_v;
   logic [P*AW-1:0] r_addr;
   logic [P*W-1:0]  rd0, rd1;
   logic          rdy0, rdy1;

   always #5 clk = ~clk;

   bsg_mem_nr1w_sync_init #(.width_p(W), .els_p(E), .rports_p(P),
                            .write_bypass_p(1'b0), .init_val_p(IV)) dut0
     (.clk_i(clk), .reset_i(reset), .w_v_i(w_v), .w_addr_i(w_addr),
      .w_data_i(w_data), .w_mask_i(w_mask), .r_v_i(r_v), .r_addr_i(r_addr),
      .r_data_o(rd0), .ready_o(rdy0));

   bsg_mem_nr1w_sync_init #(.width_p(W), .els_p(E), .rports_p(P),
                            .write_bypass_p(1'b1), .init_val_p(IV)) dut1
     (.clk_i(clk), .reset_i(reset), .w_v_i(w_v), .w_addr_i(w_addr),
      .w_data_i(w_data), .w_mask_i(w_mask), .r_v_i(r_v), .r_addr_i(r_addr),
      .r_data_o(rd1), .ready_o(rdy1));

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] m_mem [E];
   logic [7:0] m_exp [2][P];
   int         m_cyc = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
         else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   function automatic logic [7:0] port(input logic [P*W-1:0] bus, input int k);
      return bus[k*W +: W];
   endfunction

   // One clock: drive inputs, advance the model, clock, then compare at negedge.
   task automatic cyc(input logic rst, input logic wv, input logic [AW-1:0] wa,
                      input logic [7:0] wd, input logic [7:0] wm,
                      input logic [P-1:0] rv, input logic [P*AW-1:0] ra);
      logic [7:0] merged;
      int         a;
      reset = rst; w_v = wv; w_addr = wa; w_data = wd; w_mask = wm;
      r_v = rv; r_addr = ra;
      if (rst) begin
         m_cyc = 0;
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < P; k++) m_exp[b][k] = 8'h00;
      end
      else if (m_cyc < E) begin
         m_mem[m_cyc] = IV;
         m_cyc++;
      end
      else begin
         merged = (m_mem[int'(wa)] & ~wm) | (wd & wm);
         for (int k = 0; k < P; k++) begin
            if (rv[k]) begin
               a = int'(ra[k*AW +: AW]);
               m_exp[0][k] = m_mem[a];
               m_exp[1][k] = (wv && (wa == ra[k*AW +: AW])) ? merged : m_mem[a];
            end
         end
         if (wv) m_mem[int'(wa)] = merged;
      end
      @(posedge clk);
      @(negedge clk);
      chk("ready_b0", {7'd0, rdy0}, {7'd0, (m_cyc >= E)});
      chk("ready_b1", {7'd0, rdy1}, {7'd0, (m_cyc >= E)});
      for (int k = 0; k < P; k++) begin
         chk($sformatf("rdata_b0_p%0d", k), port(rd0, k), m_exp[0][k]);
         chk($sformatf("rdata_b1_p%0d", k), port(rd1, k), m_exp[1][k]);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0, '0, '0);
   endtask

   task automatic rst1();
      cyc(1'b1, 1'b0, '0, '0, '0, '0, '0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [7:0] d, input logic [7:0] m);
      cyc(1'b0, 1'b1, a, d, m, '0, '0);
   endtask

   task automatic rd_all(input logic [AW-1:0] a);
      cyc(1'b0, 1'b0, '0, '0, '0, 3'b111, {a, a, a});
   endtask

   initial begin
      logic [AW-1:0]   wa;
      logic [P*AW-1:0] ra;
      logic [7:0]      wm;
      for (int i = 0; i < E; i++) m_mem[i] = 8'h00;
      for (int b = 0; b < 2; b++)
         for (int k = 0; k < P; k++) m_exp[b][k] = 8'h00;
      reset = 1'b1; w_v = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
      r_v = '0; r_addr = '0;
      @(negedge clk);

      // reset, then sweep; ready rises after exactly 12 init writes
      rst1(); rst1();
      idle(11);
      chk("sweep_ready_low_b0", {7'd0, rdy0}, 8'd0);
      idle(1);
      chk("sweep_ready_high_b1", {7'd0, rdy1}, 8'd1);
      for (int a = 0; a < E; a++) rd_all(AW'(a));
      chk("init_val_p2", port(rd0, 2), 8'hA5);

      // write latency and hold
      wr(4'd5, 8'h3C, 8'hFF);
      rd_all(4'd5);
      idle(3);
      for (int k = 0; k < P; k++) chk("hold_b1", port(rd1, k), 8'h3C);

      // masked write
      wr(4'd2, 8'h0F, 8'hF0);
      rd_all(4'd2);
      chk("masked_b0", port(rd0, 0), 8'h05);
      chk("masked_b1", port(rd1, 2), 8'h05);

      // same-cycle collision: port 1 reads addr 7, port 2 reads addr 0
      cyc(1'b0, 1'b1, 4'd7, 8'h11, 8'hFF, 3'b110, {4'd0, 4'd7, 4'd0});
      chk("coll_p1_b0", port(rd0, 1), 8'hA5);
      chk("coll_p1_b1", port(rd1, 1), 8'h11);
      chk("coll_p2_b0", port(rd0, 2), 8'hA5);
      chk("coll_p2_b1", port(rd1, 2), 8'hA5);
      rd_all(4'd7);
      chk("after_coll_b0", port(rd0, 0), 8'h11);
      chk("after_coll_b1", port(rd1, 0), 8'h11);

      // reset during traffic
      wr(4'd1, 8'h77, 8'hFF);
      wr(4'd3, 8'h99, 8'hFF);
      rst1();
      chk("rst_ready_b0", {7'd0, rdy0}, 8'd0);
      chk("rst_rdata_b1", port(rd1, 0), 8'h00);
      idle(E);
      rd_all(4'd1);
      chk("rst_addr1", port(rd0, 0), 8'hA5);
      rd_all(4'd3);
      chk("rst_addr3", port(rd1, 1), 8'hA5);

      // reset at sweep cycle 6 restarts the sweep from zero
      rst1();
      idle(6);
      rst1();
      idle(E - 1);
      chk("restart_ready_low", {7'd0, rdy1}, 8'd0);
      idle(1);
      chk("restart_ready_high", {7'd0, rdy0}, 8'd1);

      // random soak
      for (int i = 0; i < 10000; i++) begin
         wa = AW'($urandom_range(0, E-1));
         wm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         for (int k = 0; k < P; k++)
            ra[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, E-1));
         cyc(1'b0, 1'($urandom_range(0, 1)), wa, 8'($urandom), wm,
             P'($urandom_range(0, 7)), ra);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
